// File: rtl/ntt_pkg.sv
// Shared constants, FSM state and bus-owner encodings for the NTT coefficient BRAM arbiter.
package ntt_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 12;
  localparam int Q      = 3329;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CORE = 1'b1
  } owner_e;

  // The core holds the BRAM from the launch cycle until the transform ends.
  function automatic owner_e owner_of(input state_e s);
    return ((s == LAUNCH) || (s == RUN)) ? OWN_CORE : OWN_HOST;
  endfunction

endpackage

// File: rtl/ntt_watchdog.sv
// Cycle counter for the transform watchdog: clear, count-enable and a combinational expire flag.
module ntt_watchdog #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th enabled cycle after a clear.
  assign expire = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ntt_bram_arbiter.sv
// Coefficient BRAM arbiter between the AXI host port and the NTT core, plus run sequencing,
// start-edge detection, status flags, watchdog abort and range rejection of host writes.
module ntt_bram_arbiter #(
  parameter int ADDR_W  = ntt_pkg::ADDR_W,
  parameter int DATA_W  = ntt_pkg::DATA_W,
  parameter int Q       = ntt_pkg::Q,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  input  logic              host_we,
  input  logic              host_en,
  output logic [DATA_W-1:0] host_dout,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  input  logic              core_we,
  input  logic              core_en,
  output logic [DATA_W-1:0] core_dout,
  input  logic              core_done,
  output logic              core_start,
  output logic              core_mode,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic              err_busy,
  output logic              err_range,
  output logic              err_timeout
);

  import ntt_pkg::*;

  state_e state_q, state_d;
  logic   start_q;
  logic   mode_q, mode_d;
  logic   done_q, done_d;
  logic   err_busy_q, err_busy_d;
  logic   err_range_q, err_range_d;
  logic   err_timeout_q, err_timeout_d;
  logic   rd_grant_q, rd_grant_d;

  logic   start_edge;
  logic   core_owns;
  logic   host_range_bad;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_expire;

  assign start_edge     = start & ~start_q;
  assign core_owns      = (owner_of(state_q) == OWN_CORE);
  assign host_range_bad = host_en & host_we & (host_din >= DATA_W'(Q));

  ntt_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    done_d        = done_q;
    err_busy_d    = err_busy_q;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          mode_d        = mode;
          done_d        = 1'b0;
          err_busy_d    = 1'b0;
          err_range_d   = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_clr  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        wd_en = 1'b1;
        // A real completion wins over a watchdog expiry landing in the same cycle.
        if (core_done) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (wd_expire) begin
          done_d        = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A host access that coincides with the start edge is still granted, so its flags stick.
    if (host_en && core_owns) begin
      err_busy_d = 1'b1;
    end
    if (host_range_bad && !core_owns) begin
      err_range_d = 1'b1;
    end
  end

  assign rd_grant_d = host_en & ~host_we & ~core_owns;

  always_comb begin
    bram_addr = host_addr;
    bram_din  = host_din;
    bram_we   = host_en & host_we & ~host_range_bad;
    bram_en   = host_en;
    if (core_owns) begin
      bram_addr = core_addr;
      bram_din  = core_din;
      bram_we   = core_we;
      bram_en   = core_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      mode_q        <= 1'b0;
      done_q        <= 1'b0;
      err_busy_q    <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      rd_grant_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      mode_q        <= mode_d;
      done_q        <= done_d;
      err_busy_q    <= err_busy_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      rd_grant_q    <= rd_grant_d;
    end
  end

  assign host_dout   = rd_grant_q ? bram_dout : '0;
  assign core_dout   = bram_dout;
  assign core_start  = (state_q == LAUNCH);
  assign core_mode   = mode_q;
  assign busy        = core_owns;
  assign irq         = (state_q == FINISH);
  assign done        = done_q;
  assign err_busy    = err_busy_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Self-checking bench for ntt_bram_arbiter with a behavioural BRAM and a reference coefficient image.
`timescale 1ns/1ps
module tb_ntt_bram_arbiter;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 12;
  localparam int Q       = 3329;
  localparam int TIMEOUT = 4096;
  localparam int CNT_W   = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_we;
  logic              host_en;
  logic [DATA_W-1:0] host_dout;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_din;
  logic              core_we;
  logic              core_en;
  logic [DATA_W-1:0] core_dout;
  logic              core_done;
  logic              core_start;
  logic              core_mode;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic              bram_en;
  logic [DATA_W-1:0] bram_dout;
  logic              busy;
  logic              done;
  logic              irq;
  logic              err_busy;
  logic              err_range;
  logic              err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem     [256];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] exp_q   [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ntt_bram_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .Q (Q), .TIMEOUT (TIMEOUT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .mode (mode),
    .host_addr (host_addr), .host_din (host_din), .host_we (host_we), .host_en (host_en),
    .host_dout (host_dout),
    .core_addr (core_addr), .core_din (core_din), .core_we (core_we), .core_en (core_en),
    .core_dout (core_dout), .core_done (core_done), .core_start (core_start),
    .core_mode (core_mode),
    .bram_addr (bram_addr), .bram_din (bram_din), .bram_we (bram_we), .bram_en (bram_en),
    .bram_dout (bram_dout),
    .busy (busy), .done (done), .irq (irq),
    .err_busy (err_busy), .err_range (err_range), .err_timeout (err_timeout)
  );

  // Behavioural single-port BRAM, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_dout <= mem[bram_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_en   = 1'b1;
    host_we   = we;
    host_addr = a;
    host_din  = d;
    tick();
    host_en = 1'b0;
    host_we = 1'b0;
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mode = 1'b0;
    host_addr = '0; host_din = '0; host_we = 1'b0; host_en = 1'b0;
    core_addr = '0; core_din = '0; core_we = 1'b0; core_en = 1'b0; core_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] outs;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    #1;
    outs = {busy, done, irq, err_busy, err_range, err_timeout, core_start, core_mode,
            bram_we, bram_en, (host_dout != 0), (bram_addr != 0), (bram_din != 0)};
    n_checks++;
    if (outs !== 13'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", outs, 13'b0);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_host_rw();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < 256; i++) begin
      d = DATA_W'($urandom_range(0, Q - 1));
      host_op(1'b1, ADDR_W'(i), d);
      ref_mem[i] = d;
    end
    host_op(1'b1, 8'd5, 12'h123);
    ref_mem[5] = 12'h123;
    host_op(1'b0, 8'd5, 12'h000);
    n_checks++;
    if (host_dout !== 12'h123) begin
      n_fail++; $display("FAIL rw_addr5: got %h expected %h", host_dout, 12'h123);
    end
    for (int i = 0; i < 60; i++) begin
      a = ADDR_W'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d = DATA_W'($urandom_range(0, Q - 1));
        host_op(1'b1, a, d);
        ref_mem[a] = d;
        exp_q.push_back('0);
      end else begin
        host_op(1'b0, a, 12'h000);
        exp_q.push_back(ref_mem[a]);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (host_dout !== e) begin
        n_fail++; $display("FAIL rw_random addr %0d: got %h expected %h", a, host_dout, e);
      end
    end
    n_checks++;
    if ({err_busy, err_range, err_timeout, done} !== 4'b0) begin
      n_fail++; $display("FAIL rw_no_flags: got %b expected 0000", {err_busy, err_range, err_timeout, done});
    end
  endtask

  task automatic test_range();
    logic [DATA_W-1:0] prior;
    logic [ADDR_W-1:0] a;
    prior     = ref_mem[7];
    host_en   = 1'b1; host_we = 1'b1; host_addr = 8'd7; host_din = DATA_W'(Q);
    #1;
    n_checks++;
    if ({bram_en, bram_we} !== 2'b10) begin
      n_fail++; $display("FAIL range_bram_ctl: got en/we %b expected 10", {bram_en, bram_we});
    end
    tick();
    host_en = 1'b0; host_we = 1'b0;
    #1;
    n_checks++;
    if (err_range !== 1'b1) begin
      n_fail++; $display("FAIL range_flag: got %b expected 1", err_range);
    end
    host_op(1'b0, 8'd7, 12'h000);
    n_checks++;
    if (host_dout !== prior) begin
      n_fail++; $display("FAIL range_unchanged: got %h expected %h", host_dout, prior);
    end
    // Q-1 is the largest legal coefficient.
    host_en = 1'b1; host_we = 1'b1; host_addr = 8'd8; host_din = DATA_W'(Q - 1);
    #1;
    n_checks++;
    if (bram_we !== 1'b1) begin
      n_fail++; $display("FAIL range_qm1_we: got %b expected 1", bram_we);
    end
    tick();
    host_en = 1'b0; host_we = 1'b0;
    ref_mem[8] = DATA_W'(Q - 1);
    host_op(1'b0, 8'd8, 12'h000);
    n_checks++;
    if (host_dout !== DATA_W'(Q - 1)) begin
      n_fail++; $display("FAIL range_qm1_read: got %h expected %h", host_dout, DATA_W'(Q - 1));
    end
    for (int i = 0; i < 8; i++) begin
      a = ADDR_W'($urandom_range(0, 255));
      host_op(1'b1, a, DATA_W'($urandom_range(Q, 4095)));
      host_op(1'b0, a, 12'h000);
      n_checks++;
      if (host_dout !== ref_mem[a]) begin
        n_fail++; $display("FAIL range_random addr %0d: got %h expected %h", a, host_dout, ref_mem[a]);
      end
    end
  endtask

  // Runs one transform whose core_done arrives in RUN cycle run_len (1-based).
  task automatic test_normal_run(input logic mode_val, input int run_len, input string tag);
    int bad;
    start = 1'b1; mode = mode_val;
    tick();
    mode = ~mode_val;
    #1;
    n_checks++;
    if ({core_start, busy, core_mode, done, err_range} !== {1'b1, 1'b1, mode_val, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL %s_launch: got start/busy/mode/done/err_range %b expected %b", tag,
        {core_start, busy, core_mode, done, err_range}, {1'b1, 1'b1, mode_val, 1'b0, 1'b0});
    end
    bad = 0;
    for (int k = 0; k < run_len; k++) begin
      tick();
      #1;
      if (busy !== 1'b1 || irq !== 1'b0 || core_start !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL %s_busy_window: got %0d bad cycles expected 0", tag, bad);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    #1;
    n_checks++;
    if ({irq, done, busy, err_timeout, core_mode} !== {1'b1, 1'b1, 1'b0, 1'b0, mode_val}) begin
      n_fail++; $display("FAIL %s_finish: got irq/done/busy/tmo/mode %b expected %b", tag,
        {irq, done, busy, err_timeout, core_mode}, {1'b1, 1'b1, 1'b0, 1'b0, mode_val});
    end
    tick();
    start = 1'b0;
    #1;
    n_checks++;
    if ({irq, done, busy} !== 3'b010) begin
      n_fail++; $display("FAIL %s_after: got irq/done/busy %b expected 010", tag, {irq, done, busy});
    end
    tick();
  endtask

  task automatic test_host_during_run();
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] cd;
    logic [ADDR_W-1:0] ca;
    logic [ADDR_W-1:0] cw;
    v  = DATA_W'($urandom_range(0, Q - 1));
    ca = ADDR_W'($urandom_range(20, 255));
    cw = ADDR_W'($urandom_range(20, 255));
    cd = DATA_W'($urandom_range(0, 4095));
    start = 1'b1;
    host_op(1'b1, 8'd10, v);
    ref_mem[10] = v;
    n_checks++;
    if ({core_start, err_busy} !== 2'b10) begin
      n_fail++; $display("FAIL hdr_edge_grant: got start/err_busy %b expected 10", {core_start, err_busy});
    end
    tick();
    core_en = 1'b1; core_we = 1'b0; core_addr = ca;
    host_en = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    #1;
    n_checks++;
    if ({bram_addr, bram_en, bram_we} !== {ca, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL hdr_mux_read: got addr %h en %b we %b expected addr %h en 1 we 0",
        bram_addr, bram_en, bram_we, ca);
    end
    tick();
    core_we = 1'b1; core_addr = cw; core_din = cd;
    host_en = 1'b1; host_we = 1'b1; host_addr = cw; host_din = 12'h055;
    #1;
    n_checks++;
    if ({host_dout, err_busy, core_dout} !== {12'h000, 1'b1, ref_mem[ca]}) begin
      n_fail++; $display("FAIL hdr_read_block: got host_dout %h err_busy %b core_dout %h expected 000 1 %h",
        host_dout, err_busy, core_dout, ref_mem[ca]);
    end
    n_checks++;
    if ({bram_din, bram_we} !== {cd, 1'b1}) begin
      n_fail++; $display("FAIL hdr_mux_write: got din %h we %b expected %h 1", bram_din, bram_we, cd);
    end
    tick();
    ref_mem[cw] = cd;
    core_en = 1'b0; core_we = 1'b0; host_en = 1'b0; host_we = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    start = 1'b0;
    #1;
    n_checks++;
    if ({err_busy, done, busy} !== 3'b110) begin
      n_fail++; $display("FAIL hdr_sticky: got err_busy/done/busy %b expected 110", {err_busy, done, busy});
    end
    host_op(1'b0, cw, 12'h000);
    n_checks++;
    if (host_dout !== cd) begin
      n_fail++; $display("FAIL hdr_core_write_kept: got %h expected %h", host_dout, cd);
    end
    host_op(1'b0, 8'd10, 12'h000);
    n_checks++;
    if (host_dout !== v) begin
      n_fail++; $display("FAIL hdr_edge_write_kept: got %h expected %h", host_dout, v);
    end
    start = 1'b1;
    tick();
    #1;
    n_checks++;
    if ({err_busy, core_start} !== 2'b01) begin
      n_fail++; $display("FAIL hdr_clear_on_start: got err_busy/start %b expected 01", {err_busy, core_start});
    end
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    int n;
    int relaunch;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    relaunch = 0;
    #1;
    while (n < TIMEOUT + 20) begin
      tick();
      n++;
      if (n == 100) start = 1'b1;
      #1;
      if (core_start === 1'b1) relaunch++;
      if (irq === 1'b1) break;
    end
    n_checks++;
    if (n != TIMEOUT + 1) begin
      n_fail++; $display("FAIL wd_latency: got irq after %0d cycles expected %0d", n, TIMEOUT + 1);
    end
    n_checks++;
    if ({err_timeout, done, busy} !== 3'b110) begin
      n_fail++; $display("FAIL wd_flags: got tmo/done/busy %b expected 110", {err_timeout, done, busy});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      if (core_start === 1'b1 || busy === 1'b1) relaunch++;
    end
    n_checks++;
    if (relaunch != 0) begin
      n_fail++; $display("FAIL wd_start_in_run_ignored: got %0d launches expected 0", relaunch);
    end
    n_checks++;
    if ({err_timeout, irq} !== 2'b10) begin
      n_fail++; $display("FAIL wd_sticky: got tmo/irq %b expected 10", {err_timeout, irq});
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int launches;
    launches = 0;
    start = 1'b1;
    tick();
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      if (core_start === 1'b1) launches++;
    end
    n_checks++;
    if (launches != 0) begin
      n_fail++; $display("FAIL b2b_level_held: got %0d launches expected 0", launches);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    #1;
    n_checks++;
    if ({irq, busy, done} !== 3'b001) begin
      n_fail++; $display("FAIL b2b_idle_done_ignored: got irq/busy/done %b expected 001", {irq, busy, done});
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    #1;
    n_checks++;
    if ({core_start, done} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_relaunch: got start/done %b expected 10", {core_start, done});
    end
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int bad_irq;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    host_op(1'b0, 8'd3, 12'h000);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, irq, err_busy, core_start} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_run: got busy/done/irq/err_busy/start %b expected 00000",
        {busy, done, irq, err_busy, core_start});
    end
    tick();
    rst = 1'b0;
    bad_irq = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      if (irq !== 1'b0 || busy !== 1'b0) bad_irq++;
    end
    n_checks++;
    if (bad_irq != 0) begin
      n_fail++; $display("FAIL rst_no_irq: got %0d bad cycles expected 0", bad_irq);
    end
    a = ADDR_W'($urandom_range(0, 255));
    d = DATA_W'($urandom_range(0, Q - 1));
    host_op(1'b1, a, d);
    ref_mem[a] = d;
    host_op(1'b0, a, 12'h000);
    n_checks++;
    if (host_dout !== d) begin
      n_fail++; $display("FAIL rst_host_regains: got %h expected %h", host_dout, d);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_host_rw();
    test_range();
    test_normal_run(1'b1, 300, "run300");
    test_normal_run(1'b0, 1, "run_min");
    for (int i = 0; i < 3; i++) begin
      test_normal_run(1'($urandom_range(0, 1)), $urandom_range(2, 500), "run_rand");
    end
    test_host_during_run();
    test_watchdog();
    test_normal_run(1'b0, TIMEOUT, "run_expiry_tie");
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
